// File: rtl/load_store_unit.sv
// Load/store unit for an RV32I core in front of a single-port, big-endian word RAM.
// Handles byte, half and word accesses by converting between the core's little-endian
// view and the RAM's big-endian byte order. Sub-word stores use a read-modify-write.
// The RAM read is combinational on mem_addr, so read data is usable in the cycle
// after the address is registered.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state_q, state_d;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem_wdata_d;
  logic [31:0]   resp_data_d;
  logic          resp_error_d;
  logic          accept;
  logic          req_illegal;
  logic          req_misaligned;
  logic [4:0]    shamt;
  logic [31:0]   le_word;
  logic [31:0]   le_shift;
  logic [31:0]   lane_mask;
  logic [31:0]   lane_data;
  logic [31:0]   merged;

  // Converts between the RAM's big-endian word and the core's little-endian view.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_we     = (state_q == WRITE);
  assign accept     = req_valid && req_ready;

  // Read path: little-endian view of the addressed word, shifted so the lane sits at bit 0.
  assign shamt    = {lane_q, 3'b000};
  assign le_word  = byte_swap(mem_rdata);
  assign le_shift = le_word >> shamt;

  // Store merge: funct3 bit 0 selects half (SH) versus byte (SB).
  assign lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign lane_data = (funct3_q[0] ? {16'h0000, wdata_q[15:0]} : {24'h000000, wdata_q[7:0]}) << shamt;
  assign merged    = (le_word & ~lane_mask) | lane_data;

  // Classify the incoming request as illegal (unsupported funct3) or misaligned.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_store) req_illegal = (req_funct3 > 3'd2);
    else           req_illegal = (req_funct3 == 3'd3) || (req_funct3 > 3'd5);
    case (req_funct3[1:0])
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Next state plus the values the response and write-data registers load at the edge.
  always_comb begin
    state_d      = state_q;
    mem_wdata_d  = mem_wdata;
    resp_data_d  = '0;
    resp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_misaligned) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
          end else if (req_store && (req_funct3 == 3'd2)) begin
            state_d     = WRITE;
            mem_wdata_d = byte_swap(req_wdata);
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (store_q) begin
          state_d     = WRITE;
          mem_wdata_d = byte_swap(merged);
        end else begin
          state_d = RESP;
          case (funct3_q)
            3'd0:    resp_data_d = {{24{le_shift[7]}}, le_shift[7:0]};
            3'd1:    resp_data_d = {{16{le_shift[15]}}, le_shift[15:0]};
            3'd2:    resp_data_d = le_word;
            3'd4:    resp_data_d = {24'h000000, le_shift[7:0]};
            3'd5:    resp_data_d = {16'h0000, le_shift[15:0]};
            default: resp_data_d = '0;
          endcase
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and request capture; response fields are non-zero only while in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      mem_wdata  <= mem_wdata_d;
      resp_data  <= resp_data_d;
      resp_error <= resp_error_d;
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata;
        mem_addr <= req_addr[ADDR_WIDTH+1:2];
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word-address width of the attached data RAM (4*2^ADDR_WIDTH bytes).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit accepts request this cycle (high only in IDLE).
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I funct3 (loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores: 0 SB, 1 SH, 2 SW).
REQ-008 req_addr  input  ADDR_WIDTH+2  byte address.
REQ-009 req_wdata  input  32  store data, little-endian register value.
REQ-010 resp_valid  output  1  one-cycle pulse; response fields valid.
REQ-011 resp_data  output  32  load result, little-endian (0 for stores and errors).
REQ-012 resp_error  output  1  misaligned or illegal request; no memory write occurred.
REQ-013 mem_addr  output  ADDR_WIDTH  word address to RAM.
REQ-014 mem_rdata  input  32  RAM read word, big-endian byte order, valid one cycle after mem_addr.
REQ-015 mem_wdata  output  32  RAM write word, big-endian byte order.
REQ-016 mem_we  output  1  RAM write enable, one-cycle pulse.

Function
REQ-017 RAM stores bytes big-endian: byte at address 4k+n sits in word k bits [31-8n:24-8n]; little-endian view of a word = full 32-bit byte swap.
REQ-018 FSM states IDLE, READ, WRITE, RESP; req_ready = (state==IDLE).
REQ-019 Request accepted when req_valid & req_ready; all req_* latched that edge; mem_addr = req_addr[ADDR_WIDTH+1:2], held until return to IDLE.
REQ-020 Accepted request illegal (load funct3 3/6/7, store funct3 >2) or misaligned (half: addr[0]!=0; word: addr[1:0]!=0): IDLE -> RESP, resp_error=1, no RAM write.
REQ-021 Legal SW: IDLE -> WRITE; legal load, SB, SH: IDLE -> READ.
REQ-022 READ: lane n = addr[1:0]; byte = LE-view bits [8n+7:8n]; half = LE-view bits [8n+15:8n]; LB/LH sign-extend, LBU/LHU zero-extend, LW full LE view; load -> RESP, store -> WRITE.
REQ-023 SB/SH merge: replace lane(s) of LE view read in READ with req_wdata[7:0] / [15:0], then byte swap to mem_wdata.
REQ-024 SW: mem_wdata = byte swap of req_wdata.
REQ-025 WRITE: mem_we=1 exactly one cycle, then RESP.
REQ-026 RESP: resp_valid=1 one cycle, then IDLE; consumer always accepts (no response backpressure).
REQ-027 Latency from accept edge (cycle 0): error resp cycle 1; load resp cycle 2; SW mem_we cycle 1, resp cycle 2; SB/SH mem_we cycle 2, resp cycle 3.
REQ-028 req_valid outside IDLE ignored; no queuing; back-to-back request accepted the cycle after RESP.
REQ-029 resp_data, resp_error held at 0 whenever resp_valid=0.

Reset
REQ-030 reset low asynchronously forces IDLE, resp_valid=0, resp_data=0, resp_error=0, mem_we=0, mem_addr=0, mem_wdata=0; req_ready=1.
REQ-031 Reset mid-operation aborts the request: no mem_we pulse, no resp_valid; first accept possible on first rising edge after reset high.

Verification
REQ-032 Word4=0x80FF7F01: LB 4 -> 0xFFFFFF80; LBU 4 -> 0x00000080; LH 6 -> 0x0000017F; LH 4 -> 0xFFFFFF80; LW 4 -> 0x017FFF80, resp_valid cycle 2.
REQ-033 Word0=0x11223344, SB addr 1 data 0x000000AB -> mem_we cycle 2, mem_wdata 0x11AB3344, resp_valid cycle 3, resp_error 0.
REQ-034 SW addr 8 data 0xDEADBEEF -> mem_we cycle 1, mem_addr 2, mem_wdata 0xEFBEADDE, resp_valid cycle 2.
REQ-035 LW addr 6 and load funct3=3 -> resp_valid cycle 1, resp_error 1, resp_data 0, mem_we never high.
REQ-036 reset low during READ of SH addr 2 -> mem_we stays 0, no resp_valid, req_ready 1; following LW 0 returns 0x44332211.
REQ-037 req_valid held high continuously with 3 loads -> exactly 3 resp_valid pulses, requests accepted only in IDLE cycles.
